memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 192 +++++++++++++++++++
 tb/tb_memory_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: M register, data-memory request FSM (IDLE/WAIT/HOLD), store lane steering, load extension.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module memory_stage (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        valid_e_i,
  input  logic [31:0] alu_result_e_i,
  input  logic [31:0] write_data_e_i,
  input  logic [4:0]  rd_e_i,
  input  logic [2:0]  width_src_e_i,
  input  logic [2:0]  result_src_e_i,
  input  logic        mem_write_e_i,
  input  logic        reg_write_e_i,
  input  logic        stall_m_i,
  input  logic        flush_m_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_m_o,
  output logic [4:0]  rd_m_o,
  output logic        reg_write_m_o,
  output logic [2:0]  result_src_m_o,
  output logic [31:0] read_data_m_o,
  output logic [31:0] forward_data_m_o,
  output logic        busy_m_o,
  output logic        misaligned_m_o
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  // width_src[1:0]: 00 word, 01 half, 10 byte; width_src[2] selects zero extension
  function automatic logic [3:0] byte_en(input logic [2:0] w, input logic [1:0] a);
    case (w[1:0])
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      2'b10:   byte_en = 4'b0001 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] w, input logic [31:0] d);
    case (w[1:0])
      2'b01:   store_data = {2{d[15:0]}};
      2'b10:   store_data = {4{d[7:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] w, input logic [1:0] a,
                                           input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[{a, 3'b000} +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    case (w[1:0])
      2'b01:   load_ext = w[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   load_ext = w[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      default: load_ext = r;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] w, input logic [1:0] a);
    case (w[1:0])
      2'b00:   is_misaligned = (a != 2'b00);
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  width_src_q, width_src_d;
  logic [2:0]  result_src_q, result_src_d;
  logic        mem_write_q, mem_write_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] hold_q, hold_d;

  logic        access_e, access_m, mis_e, mis_m, load_en, req;
  logic [31:0] rdata_ext;

  assign access_m = valid_q & (mem_write_q | (result_src_q == 3'b001));

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_e = is_misaligned(width_src_e_i, alu_result_e_i[1:0]);
  assign mis_m = access_m & is_misaligned(width_src_q, alu_result_q[1:0]);
`else
  assign mis_e = 1'b0;
  assign mis_m = 1'b0;
`endif

  // A flushed or trapped entry never starts a request
  assign access_e  = ~flush_m_i & valid_e_i & (mem_write_e_i | (result_src_e_i == 3'b001)) & ~mis_e;
  assign req       = (state_q == WAIT);
  assign busy_m_o  = req & ~dmem_ack_i;
  assign load_en   = ~stall_m_i & ~busy_m_o;
  assign rdata_ext = load_ext(width_src_q, alu_result_q[1:0], dmem_rdata_i);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    rd_d         = rd_q;
    width_src_d  = width_src_q;
    result_src_d = result_src_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    hold_d       = hold_q;
    if (load_en) begin
      alu_result_d = alu_result_e_i;
      write_data_d = write_data_e_i;
      rd_d         = rd_e_i;
      width_src_d  = width_src_e_i;
      valid_d      = valid_e_i & ~flush_m_i;
      result_src_d = flush_m_i ? 3'b000 : result_src_e_i;
      mem_write_d  = mem_write_e_i & ~flush_m_i;
      reg_write_d  = reg_write_e_i & ~flush_m_i;
      state_d      = access_e ? WAIT : IDLE;
    end else if (state_q == WAIT) begin
      // Flush mid-request kills the entry but the memory handshake must still complete
      if (flush_m_i) begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
      end
      if (dmem_ack_i) begin
        if (valid_q & ~flush_m_i) begin
          hold_d  = rdata_ext;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      width_src_q  <= '0;
      result_src_q <= '0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      width_src_q  <= width_src_d;
      result_src_q <= result_src_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      hold_q       <= hold_d;
    end
  end

  // Request fields are gated by req so the bus idles at zero
  assign dmem_req_o    = req;
  assign dmem_we_o     = req & mem_write_q;
  assign dmem_addr_o   = req ? {alu_result_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o     = req ? byte_en(width_src_q, alu_result_q[1:0]) : 4'h0;
  assign dmem_wdata_o  = req ? store_data(width_src_q, write_data_q) : 32'h0;

  assign valid_m_o        = valid_q;
  assign rd_m_o           = rd_q;
  assign reg_write_m_o    = reg_write_q & ~mis_m;
  assign result_src_m_o   = result_src_q;
  assign forward_data_m_o = alu_result_q;
  assign misaligned_m_o   = mis_m;

  always_comb begin
    case (state_q)
      WAIT:    read_data_m_o = rdata_ext;
      HOLD:    read_data_m_o = hold_q;
      default: read_data_m_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: store/load lanes, wait states, hold, flush, reset, misalignment.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_e;
  logic [31:0] alu_e, wd_e;
  logic [4:0]  rd_e;
  logic [2:0]  width_e, rsrc_e;
  logic        mw_e, rw_e, stall, flush;
  logic        req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        valid_m, rw_m, busy, mis;
  logic [4:0]  rd_m;
  logic [2:0]  rsrc_m;
  logic [31:0] rdm, fwd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .valid_e_i(valid_e), .alu_result_e_i(alu_e), .write_data_e_i(wd_e), .rd_e_i(rd_e),
    .width_src_e_i(width_e), .result_src_e_i(rsrc_e), .mem_write_e_i(mw_e), .reg_write_e_i(rw_e),
    .stall_m_i(stall), .flush_m_i(flush),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata),
    .valid_m_o(valid_m), .rd_m_o(rd_m), .reg_write_m_o(rw_m), .result_src_m_o(rsrc_m),
    .read_data_m_o(rdm), .forward_data_m_o(fwd), .busy_m_o(busy), .misaligned_m_o(mis)
  );

  task automatic set_e(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic [2:0] w, input logic [2:0] rs, input logic m, input logic rw);
    valid_e = v; alu_e = a; wd_e = d; rd_e = r; width_e = w; rsrc_e = rs; mw_e = m; rw_e = rw;
  endtask

  task automatic clear_e();
    set_e(1'b0, 32'h0, 32'h0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; rdata = 32'h0;
    set_e(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd9, 3'b000, 3'b001, 1'b0, 1'b1);
    step(); step();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (valid_m !== 1'b0 || rw_m !== 1'b0 || busy !== 1'b0 || mis !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got v%b rw%b busy%b mis%b want 0", valid_m, rw_m, busy, mis); end
    checks++; if (fwd !== 32'h0 || rdm !== 32'h0 || be !== 4'h0 || rd_m !== 5'd0) begin
      errors++; $display("FAIL reset_data got fwd %h rd %h be %b rd_m %0d want 0", fwd, rdm, be, rd_m); end
    clear_e();
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_store_byte();
    step();
    set_e(1'b1, 32'h0000_1003, 32'h0000_00AB, 5'd0, 3'b010, 3'b000, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_busy_pre got %b want 0", busy); end
    step();
    clear_e(); ack = 1'b1; #1;
    checks++; if (req !== 1'b1 || we !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL sb_req got req%b we%b busy%b want 1 1 0", req, we, busy); end
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", be); end
    checks++; if (wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h want ababab ab", wdata); end
    checks++; if (addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", addr); end
    step(); ack = 1'b0; #1;
    checks++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sb_done got req%b busy%b want 0 0", req, busy); end
  endtask

  task automatic test_load_wait();
    set_e(1'b1, 32'h0000_1002, 32'h0, 5'd5, 3'b010, 3'b001, 1'b0, 1'b1);
    step();
    clear_e(); ack = 1'b0; #1;
    checks++; if (busy !== 1'b1 || req !== 1'b1 || we !== 1'b0) begin
      errors++; $display("FAIL lb_wait1 got busy%b req%b we%b want 1 1 0", busy, req, we); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lb_wait2 got busy %b want 1", busy); end
    ack = 1'b1; rdata = 32'h0080_0000; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lb_ack_busy got %b want 0", busy); end
    checks++; if (rdm !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", rdm); end
    checks++; if (valid_m !== 1'b1 || rd_m !== 5'd5 || rw_m !== 1'b1 || rsrc_m !== 3'b001) begin
      errors++; $display("FAIL lb_wb got v%b rd%0d rw%b rs%b want 1 5 1 001", valid_m, rd_m, rw_m, rsrc_m); end
    step(); ack = 1'b0; rdata = 32'h0; #1;
    checks++; if (req !== 1'b0 || rdm !== 32'h0) begin errors++; $display("FAIL lb_idle got req%b rd %h want 0 0", req, rdm); end
  endtask

  task automatic test_load_hold();
    set_e(1'b1, 32'h0000_2002, 32'h0, 5'd6, 3'b101, 3'b001, 1'b0, 1'b1);
    step();
    clear_e(); stall = 1'b1; ack = 1'b1; rdata = 32'hBEEF_0000; #1;
    checks++; if (rdm !== 32'h0000_BEEF || busy !== 1'b0) begin
      errors++; $display("FAIL hu_wait got %h busy%b want 0000beef 0", rdm, busy); end
    step(); ack = 1'b0; rdata = 32'h0; #1;
    checks++; if (req !== 1'b0 || rdm !== 32'h0000_BEEF) begin
      errors++; $display("FAIL hu_hold1 got req%b %h want 0 0000beef", req, rdm); end
    step();
    checks++; if (rdm !== 32'h0000_BEEF || valid_m !== 1'b1 || rd_m !== 5'd6) begin
      errors++; $display("FAIL hu_hold2 got %h v%b rd%0d want 0000beef 1 6", rdm, valid_m, rd_m); end
    stall = 1'b0;
    step();
    checks++; if (rdm !== 32'h0 || valid_m !== 1'b0 || req !== 1'b0) begin
      errors++; $display("FAIL hu_release got %h v%b req%b want 0 0 0", rdm, valid_m, req); end
  endtask

  task automatic test_flush_wait();
    set_e(1'b1, 32'h0000_4000, 32'h0, 5'd3, 3'b000, 3'b001, 1'b0, 1'b1);
    step();
    clear_e(); flush = 1'b1;
    step(); flush = 1'b0; #1;
    checks++; if (req !== 1'b1 || busy !== 1'b1 || addr !== 32'h0000_4000) begin
      errors++; $display("FAIL fl_req got req%b busy%b addr %h want 1 1 00004000", req, busy, addr); end
    checks++; if (valid_m !== 1'b0 || rw_m !== 1'b0) begin
      errors++; $display("FAIL fl_kill got v%b rw%b want 0 0", valid_m, rw_m); end
    ack = 1'b1; rdata = 32'h1234_5678;
    step(); ack = 1'b0; rdata = 32'h0; #1;
    checks++; if (req !== 1'b0 || rdm !== 32'h0) begin errors++; $display("FAIL fl_idle got req%b %h want 0 0", req, rdm); end
  endtask

  task automatic test_reset_mid_wait();
    set_e(1'b1, 32'h0000_5000, 32'h0, 5'd4, 3'b000, 3'b001, 1'b0, 1'b1);
    step();
    clear_e(); #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rmw_pre got req %b want 1", req); end
    #1 reset_n = 1'b0; #1;
    checks++; if (req !== 1'b0 || valid_m !== 1'b0 || busy !== 1'b0 || addr !== 32'h0) begin
      errors++; $display("FAIL rmw_async got req%b v%b busy%b addr %h want 0", req, valid_m, busy, addr); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_misalign();
    set_e(1'b1, 32'h0000_3002, 32'h0, 5'd7, 3'b000, 3'b001, 1'b0, 1'b1);
    step();
    clear_e(); #1;
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (mis !== 1'b1 || req !== 1'b0 || rw_m !== 1'b0) begin
      errors++; $display("FAIL mis_trap got mis%b req%b rw%b want 1 0 0", mis, req, rw_m); end
    step();
    checks++; if (mis !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL mis_clear got mis%b req%b want 0 0", mis, req); end
`else
    checks++; if (mis !== 1'b0 || req !== 1'b1 || addr !== 32'h0000_3000 || be !== 4'b1111) begin
      errors++; $display("FAIL mis_issue got mis%b req%b addr %h be %b want 0 1 00003000 1111", mis, req, addr, be); end
    ack = 1'b1;
    step(); ack = 1'b0; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mis_done got req%b want 0", req); end
`endif
  endtask

  task automatic test_back_to_back();
    set_e(1'b1, 32'h0000_6000, 32'h1111_1111, 5'd0, 3'b000, 3'b000, 1'b1, 1'b0);
    step();
    set_e(1'b1, 32'h0000_6006, 32'h0000_CAFE, 5'd0, 3'b001, 3'b000, 1'b1, 1'b0);
    ack = 1'b1; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0000_6000 || be !== 4'b1111 || wdata !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_first got req%b addr %h be %b wd %h", req, addr, be, wdata); end
    step();
    clear_e();
    checks++; if (req !== 1'b1 || addr !== 32'h0000_6004 || be !== 4'b1100 || wdata !== 32'hCAFE_CAFE) begin
      errors++; $display("FAIL b2b_second got req%b addr %h be %b wd %h want 1 00006004 1100 cafecafe", req, addr, be, wdata); end
    step(); ack = 1'b0; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL b2b_done got req%b want 0", req); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait();
    test_load_hold();
    test_flush_wait();
    test_reset_mid_wait();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
